// File: rtl/hls_perf_monitor.sv
// Per-channel observer for ap_ctrl_hs / ap_ctrl_chain handshakes: counts starts,
// completions, busy and stall cycles, and tracks last/max latency of the oldest transaction.
module hls_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              enable,
  input  logic              clear,
  input  logic              finish,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              frozen,
  output logic [NUM_CH-1:0] overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] starts;
    logic [CNT_W-1:0] dones;
    logic [CNT_W-1:0] busy;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] last_lat;
    logic [CNT_W-1:0] max_lat;
    logic [CNT_W-1:0] lat;
    state_e           state;
    logic             ovf;
  } ch_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ch_t              ch_q [NUM_CH];
  ch_t              ch_d [NUM_CH];
  logic             frozen_q, frozen_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             active;
  ch_t              sel_ch;
  logic [CNT_W-1:0] rd_word;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // One active cycle of a channel; cap is the latency that a completion would report.
  function automatic ch_t ch_next(input ch_t c, input logic st, input logic rdy,
                                  input logic dn, input logic cn);
    ch_t              n;
    logic [CNT_W-1:0] cap;
    logic             complete;
    logic             sat_hit;
    n        = c;
    cap      = c.lat;
    complete = 1'b0;
    sat_hit  = 1'b0;
    if (st && rdy) begin
      sat_hit  = sat_hit | (c.starts == CNT_MAX);
      n.starts = sat_inc(c.starts);
    end
    case (c.state)
      IDLE: begin
        if (st) begin
          cap     = CNT_ONE;
          n.lat   = CNT_ONE;
          sat_hit = sat_hit | (c.busy == CNT_MAX);
          n.busy  = sat_inc(c.busy);
          if (dn && cn)  complete = 1'b1;
          else if (dn)   n.state  = DONE_WAIT;
          else           n.state  = BUSY;
        end
      end
      BUSY: begin
        sat_hit = sat_hit | (c.busy == CNT_MAX) | (c.lat == CNT_MAX);
        n.busy  = sat_inc(c.busy);
        cap     = sat_inc(c.lat);
        n.lat   = cap;
        if (dn && cn) begin
          complete = 1'b1;
          n.state  = IDLE;
        end else if (dn) begin
          n.state  = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        sat_hit = sat_hit | (c.stall == CNT_MAX);
        n.stall = sat_inc(c.stall);
        if (cn) begin
          complete = 1'b1;
          n.state  = IDLE;
        end
      end
      default: n.state = IDLE;
    endcase
    if (complete) begin
      sat_hit    = sat_hit | (c.dones == CNT_MAX);
      n.dones    = sat_inc(c.dones);
      n.last_lat = cap;
      if (cap > c.max_lat) n.max_lat = cap;
    end
    n.ovf = c.ovf | sat_hit;
    return n;
  endfunction

  always_comb begin
    active   = enable & ~frozen_q & ~clear;
    frozen_d = frozen_q | finish;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clear)       ch_d[c] = '0;
      else if (active) ch_d[c] = ch_next(ch_q[c], ap_start[c], ap_ready[c],
                                         ap_done[c], ap_continue[c]);
      else             ch_d[c] = ch_q[c];
    end
  end

  // Read mux works on the registered state, so a read never sees this cycle's update.
  always_comb begin
    sel_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) sel_ch = ch_q[c];
    end
    case (rd_sel)
      3'd0:    rd_word = sel_ch.starts;
      3'd1:    rd_word = sel_ch.dones;
      3'd2:    rd_word = sel_ch.busy;
      3'd3:    rd_word = sel_ch.stall;
      3'd4:    rd_word = sel_ch.last_lat;
      3'd5:    rd_word = sel_ch.max_lat;
      3'd6:    rd_word = {{(CNT_W-2){1'b0}}, sel_ch.state};
      default: rd_word = {{(CNT_W-1){1'b0}}, sel_ch.ovf};
    endcase
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_word : rd_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
      frozen_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) ch_q[c] <= ch_d[c];
      frozen_q   <= frozen_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    overflow = '0;
    for (int c = 0; c < NUM_CH; c++) overflow[c] = ch_q[c].ovf;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign frozen   = frozen_q;

endmodule
